// File: rtl/tow_engine.sv
// Two-player tug-of-war: button edges pull a one-hot rope marker; pulling it off
// the end wins a point, which is displayed for HOLD cycles before play resumes.
module tow_engine #(
  parameter int HALF       = 4,
  parameter int SCORE_W    = 4,
  parameter int MATCH_WINS = 7,
  parameter int HOLD       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                p1_in,
  input  logic                p2_in,
  input  logic                start,
  output logic [2*HALF:0]     pos,
  output logic [SCORE_W-1:0]  score1,
  output logic [SCORE_W-1:0]  score2,
  output logic [1:0]          point_win,
  output logic                match_over,
  output logic                winner
);

  localparam int PW = 2*HALF + 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD + 1) : 1;
  localparam logic [PW-1:0]      CENTRE    = PW'(1) << HALF;
  localparam logic [SCORE_W-1:0] WINS_C    = SCORE_W'(MATCH_WINS);
  localparam logic [HW-1:0]      HOLD_LOAD = HW'(HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_PLAY       = 2'd1,
    S_POINT      = 2'd2,
    S_MATCH_OVER = 2'd3
  } state_t;

  state_t        state_r;
  logic [HW-1:0] hold_r;
  logic          p1_prev_r;
  logic          p2_prev_r;
  logic          press1_s;
  logic          press2_s;

  assign press1_s = p1_in & ~p1_prev_r;
  assign press2_s = p2_in & ~p2_prev_r;

  // Button history: forced high in reset so a button held through release is not a press
  always_ff @(posedge clk) begin
    if (!reset) begin
      p1_prev_r <= 1'b1;
      p2_prev_r <= 1'b1;
    end else begin
      p1_prev_r <= p1_in;
      p2_prev_r <= p2_in;
    end
  end

  // Game FSM; the rope position is kept directly as the one-hot marker
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      pos        <= CENTRE;
      score1     <= '0;
      score2     <= '0;
      point_win  <= 2'b00;
      match_over <= 1'b0;
      winner     <= 1'b0;
      hold_r     <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r <= S_PLAY;
            pos     <= CENTRE;
            score1  <= '0;
            score2  <= '0;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_PLAY: begin
          if (press1_s && !press2_s) begin
            if (pos[PW-1]) begin
              if (score1 < WINS_C) begin
                score1 <= score1 + SCORE_W'(1);
              end else begin
                score1 <= score1;
              end
              point_win <= 2'b01;
              hold_r    <= HOLD_LOAD;
              state_r   <= S_POINT;
            end else begin
              pos <= {pos[PW-2:0], 1'b0};
            end
          end else if (press2_s && !press1_s) begin
            if (pos[0]) begin
              if (score2 < WINS_C) begin
                score2 <= score2 + SCORE_W'(1);
              end else begin
                score2 <= score2;
              end
              point_win <= 2'b10;
              hold_r    <= HOLD_LOAD;
              state_r   <= S_POINT;
            end else begin
              pos <= {1'b0, pos[PW-1:1]};
            end
          end else begin
            state_r <= S_PLAY;
          end
        end
        S_POINT: begin
          if (hold_r == '0) begin
            pos       <= CENTRE;
            point_win <= 2'b00;
            if ((point_win[0] && (score1 == WINS_C)) ||
                (point_win[1] && (score2 == WINS_C))) begin
              state_r    <= S_MATCH_OVER;
              match_over <= 1'b1;
              winner     <= point_win[1];
            end else begin
              state_r <= S_PLAY;
            end
          end else begin
            hold_r <= hold_r - HW'(1);
          end
        end
        S_MATCH_OVER: begin
          if (start) begin
            state_r    <= S_PLAY;
            pos        <= CENTRE;
            score1     <= '0;
            score2     <= '0;
            match_over <= 1'b0;
            winner     <= 1'b0;
          end else begin
            state_r <= S_MATCH_OVER;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
